// File: rtl/gs_sram_pkg.sv
// ============================================================================
// Module      : gs_sram_pkg
// Description : Shared widths and FSM state encoding for the GS SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package gs_sram_pkg;

    localparam int C_ADDR_W  = 21;
    localparam int C_WORD_W  = 20;
    localparam int C_DATA_W  = 8;
    localparam int C_SRAM_DW = 16;
    localparam int C_CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/gs_sram_ctrl.sv
// ============================================================================
// Module      : gs_sram_ctrl
// Description : Timed byte-access responder between the GS core request port
//               and a 16-bit asynchronous SRAM, with a one-entry read cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gs_sram_ctrl
    import gs_sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [C_ADDR_W-1:0]   addr,
    input  logic [C_DATA_W-1:0]   din,
    input  logic                  rd,
    input  logic                  wr,
    output logic [C_DATA_W-1:0]   dout,
    output logic                  ready,
    output logic [C_WORD_W-1:0]   sram_addr,
    output logic [C_SRAM_DW-1:0]  sram_dq_o,
    input  logic [C_SRAM_DW-1:0]  sram_dq_i,
    output logic                  sram_dq_oe,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_lb_n,
    output logic                  sram_ub_n
);

    localparam logic [C_CNT_W-1:0] C_WAIT_LOAD = C_CNT_W'(WAIT_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;

    logic                  r_rd_q;
    logic                  r_wr_q;
    logic [C_ADDR_W-1:0]   r_addr;
    logic [C_DATA_W-1:0]   r_wdata;
    logic [C_CNT_W-1:0]    r_cnt;
    logic [C_DATA_W-1:0]   r_dout;
    logic                  r_cache_vld;
    logic [C_ADDR_W-1:0]   r_cache_addr;
    logic [C_DATA_W-1:0]   r_cache_data;

    logic                  w_idle;
    logic                  w_rd_edge;
    logic                  w_wr_edge;
    logic                  w_cache_match;
    logic                  w_start_wr;
    logic                  w_start_rd;
    logic                  w_hit_rd;
    logic                  w_cnt_zero;
    logic                  w_rd_done;
    logic [C_DATA_W-1:0]   w_rd_byte;

    // A write edge always wins; a simultaneous read edge is simply dropped.
    assign w_idle        = (r_state == ST_IDLE);
    assign w_rd_edge     = rd & ~r_rd_q;
    assign w_wr_edge     = wr & ~r_wr_q;
    assign w_cache_match = r_cache_vld && (r_cache_addr == addr);
    assign w_start_wr    = w_idle & w_wr_edge;
    assign w_start_rd    = w_idle & w_rd_edge & ~w_wr_edge & ~w_cache_match;
    assign w_hit_rd      = w_idle & w_rd_edge & ~w_wr_edge &  w_cache_match;
    assign w_cnt_zero    = (r_cnt == '0);
    assign w_rd_done     = (r_state == ST_RD) && w_cnt_zero;
    assign w_rd_byte     = r_addr[C_ADDR_W-1] ? sram_dq_i[15:8] : sram_dq_i[7:0];

    assign dout      = r_dout;
    assign sram_addr = r_addr[C_WORD_W-1:0];
    assign sram_dq_o = {r_wdata, r_wdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_wr) begin
                    w_next = ST_WR_SETUP;
                end else if (w_start_rd) begin
                    w_next = ST_RD;
                end
            end
            ST_RD: begin
                if (w_cnt_zero) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WR_SETUP: w_next = ST_WR_PULSE;
            ST_WR_PULSE: begin
                if (w_cnt_zero) begin
                    w_next = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD:  w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset releases them at once.
    always_comb begin
        ready      = 1'b0;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_RD: begin
                sram_oe_n = 1'b0;
                sram_lb_n =  r_addr[C_ADDR_W-1];
                sram_ub_n = ~r_addr[C_ADDR_W-1];
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                sram_dq_oe = 1'b1;
                sram_lb_n  =  r_addr[C_ADDR_W-1];
                sram_ub_n  = ~r_addr[C_ADDR_W-1];
            end
            ST_WR_PULSE: begin
                sram_dq_oe = 1'b1;
                sram_we_n  = 1'b0;
                sram_lb_n  =  r_addr[C_ADDR_W-1];
                sram_ub_n  = ~r_addr[C_ADDR_W-1];
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_q       <= 1'b0;
            r_wr_q       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_cache_vld  <= 1'b0;
            r_cache_addr <= '0;
            r_cache_data <= '0;
        end else begin
            r_rd_q <= rd;
            r_wr_q <= wr;

            if (w_start_rd || w_start_wr) begin
                r_addr <= addr;
            end
            if (w_start_wr) begin
                r_wdata <= din;
                if (w_cache_match) begin
                    r_cache_data <= din;
                end
            end

            if (w_start_rd || (r_state == ST_WR_SETUP)) begin
                r_cnt <= C_WAIT_LOAD;
            end else if (((r_state == ST_RD) || (r_state == ST_WR_PULSE)) && !w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_hit_rd) begin
                r_dout <= r_cache_data;
            end
            if (w_rd_done) begin
                r_dout       <= w_rd_byte;
                r_cache_vld  <= 1'b1;
                r_cache_addr <= r_addr;
                r_cache_data <= w_rd_byte;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gs_sram_ctrl.sv
// ============================================================================
// Module      : tb_gs_sram_ctrl
// Description : Self-checking bench for gs_sram_ctrl against a byte-level
//               memory and one-entry cache reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gs_sram_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] addr;
    logic [7:0]  din;
    logic        rd;
    logic        wr;
    logic [7:0]  dout;
    logic        ready;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_lb_n;
    logic        sram_ub_n;

    logic [15:0] sram_mem [0:31];
    logic [7:0]  ref_mem  [0:63];
    logic        ref_vld;
    logic [20:0] ref_caddr;
    logic [7:0]  ref_cdata;

    int n_checks = 0;
    int n_errors = 0;

    gs_sram_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .din        (din),
        .rd         (rd),
        .wr         (wr),
        .dout       (dout),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_lb_n  (sram_lb_n),
        .sram_ub_n  (sram_ub_n)
    );

    initial forever #5 clk = ~clk;

    // Asynchronous SRAM: data driven only while OE is low, lanes written while WE is low.
    always_comb sram_dq_i = sram_oe_n ? 16'hDEAD : sram_mem[sram_addr[4:0]];

    always @(posedge clk) begin
        if (!sram_we_n) begin
            if (!sram_lb_n) sram_mem[sram_addr[4:0]][7:0]  <= sram_dq_o[7:0];
            if (!sram_ub_n) sram_mem[sram_addr[4:0]][15:8] <= sram_dq_o[15:8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ridx(input logic [20:0] a);
        return {26'd0, a[20], a[4:0]};
    endfunction

    task automatic run_access(input bit do_rd, input bit do_wr,
                              input logic [20:0] a, input logic [7:0] d);
        bit   hit;
        int   exp_low, exp_oe, exp_we, exp_dq;
        int   low, oe, we, dq, bad, first_we, first_dq;
        logic [7:0] exp_dout;
        hit      = !do_wr && do_rd && ref_vld && (ref_caddr == a);
        exp_low  = do_wr ? W + 2 : (hit ? 0 : W);
        exp_oe   = (!do_wr && !hit) ? W : 0;
        exp_we   = do_wr ? W : 0;
        exp_dq   = do_wr ? W + 2 : 0;
        exp_dout = hit ? ref_cdata : ref_mem[ridx(a)];
        low = 0; oe = 0; we = 0; dq = 0; bad = 0; first_we = -1; first_dq = -1;

        @(negedge clk);
        addr = a; din = d; rd = do_rd; wr = do_wr;
        @(posedge clk); #1;
        for (int n = 0; n < W + 6; n++) begin
            if (!ready) begin
                low++;
                if (sram_lb_n !== a[20] || sram_ub_n !== ~a[20] || sram_addr !== a[19:0]) bad++;
                if (do_wr && sram_dq_oe && sram_dq_o !== {d, d}) bad++;
            end else if ({sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe} !== 5'b11110) begin
                bad++;
            end
            if (!sram_oe_n) oe++;
            if (!sram_we_n) begin
                we++;
                if (!sram_dq_oe) bad++;
                if (first_we < 0) first_we = n;
            end
            if (sram_dq_oe) begin
                dq++;
                if (first_dq < 0) first_dq = n;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;

        check("ready_low_cycles", low, exp_low);
        check("oe_low_cycles", oe, exp_oe);
        check("we_low_cycles", we, exp_we);
        check("dq_oe_cycles", dq, exp_dq);
        check("lane_addr_data", bad, 0);
        if (do_wr) begin
            check("wr_setup_order", first_we - first_dq, 1);
        end else begin
            check("dout", dout, exp_dout);
        end

        if (do_wr) begin
            ref_mem[ridx(a)] = d;
            if (ref_vld && ref_caddr == a) ref_cdata = d;
        end else if (!hit) begin
            ref_vld   = 1'b1;
            ref_caddr = a;
            ref_cdata = ref_mem[ridx(a)];
        end
    endtask

    initial begin
        logic [20:0] a;
        int          k;
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
        ref_vld = 1'b0; ref_caddr = '0; ref_cdata = '0;
        for (int w = 0; w < 32; w++) begin
            ref_mem[w]      = 8'($urandom);
            ref_mem[32 + w] = 8'($urandom);
        end
        ref_mem[16]      = 8'h5A;
        ref_mem[32 + 16] = 8'hA5;
        for (int w = 0; w < 32; w++) sram_mem[w] = {ref_mem[32 + w], ref_mem[w]};

        #12;
        check("rst_ready", ready, 1);
        check("rst_dout", dout, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_dq", {sram_dq_o, sram_dq_oe}, 0);
        check("rst_strobes", {sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 4'hF);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        run_access(1, 0, 21'h100010, 8'h00);
        check("read_miss_a5", dout, 8'hA5);
        run_access(1, 0, 21'h100010, 8'h00);
        run_access(0, 1, 21'h000010, 8'h3C);
        run_access(1, 0, 21'h000010, 8'h00);
        check("read_after_write_3c", dout, 8'h3C);
        run_access(1, 0, 21'h100010, 8'h00);
        run_access(1, 1, 21'h100010, 8'h77);
        run_access(1, 0, 21'h100010, 8'h00);
        check("cache_updated_77", dout, 8'h77);

        // Reset in the middle of the write pulse: access is lost, cache cleared.
        @(negedge clk);
        addr = 21'h000005; din = 8'h99; wr = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_pulse_entered", sram_we_n, 0);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_we_n", sram_we_n, 1);
        check("rst_mid_dq_oe", sram_dq_oe, 0);
        check("rst_mid_ready", ready, 1);
        @(negedge clk); wr = 1'b0;
        @(negedge clk); reset = 1'b0;
        ref_vld = 1'b0;
        run_access(1, 0, 21'h100010, 8'h00);
        run_access(1, 0, 21'h000005, 8'h00);

        for (int i = 0; i < 80; i++) begin
            a = {1'($urandom_range(0, 1)), 15'd0, 5'($urandom_range(0, 7))};
            k = $urandom_range(0, 3);
            case (k)
                0, 1:    run_access(1, 0, a, 8'($urandom));
                2:       run_access(0, 1, a, 8'($urandom));
                default: run_access(1, 1, a, 8'($urandom));
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gs_sram_ctrl.md
# gs_sram_ctrl

Responder for the General Sound memory request port: it accepts byte read/write requests from the GS core (`addr`, `din`, `rd`, `wr`), runs timed accesses on an external asynchronous 16-bit SRAM, and returns `dout` and `ready`. It replaces the combinational SRAM hookup on boards without DDR3. It sits between `tsconf` (GS_ADDR/GS_DI/GS_DO/GS_RD/GS_WR/GS_WAIT) and the SRAM pins. The top level owns the DQ tristate buffer and the out-of-range mask.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: number of clk cycles the SRAM strobe is held low. Legal range 1..15.

Ports:
- `clk`  in  1  system clock (clk_sys).
- `reset`  in  1  asynchronous, active-high.
- `addr`  in  21  GS byte address. `addr[20]` selects the byte lane (1 = upper), `addr[19:0]` is the SRAM word address.
- `din`  in  8  write data.
- `rd`  in  1  read request, level, held by the initiator until `ready`.
- `wr`  in  1  write request, level, held by the initiator until `ready`.
- `dout`  out  8  read data.
- `ready`  out  1  high = idle or access complete. The top drives GS_WAIT = ~ready.
- `sram_addr`  out  20  SRAM word address.
- `sram_dq_o`  out  16  write data, `{din,din}`.
- `sram_dq_i`  in  16  read data from the pins.
- `sram_dq_oe`  out  1  DQ output enable.
- `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n`  out  1 each  active-low SRAM strobes.

## Operation
- **Edge detection.** Registered copies of `rd` and `wr` are kept. A request starts on a rising edge: a signal sampled high that was low on the previous cycle.
- **Priority.** If both `rd` and `wr` rise in the same cycle, the write is performed and the read edge is discarded.
- **Edges while busy.** Any edge seen while not in IDLE is ignored. The initiator must wait for `ready`.
- **States:**
  - IDLE
  - RD: `oe_n`=0, lane strobe low
  - WR_SETUP: `dq_oe`=1, `we_n`=1
  - WR_PULSE: `we_n`=0
  - WR_HOLD: `we_n`=1, `dq_oe`=1
- **Transitions:**
  - IDLE → RD on a read edge that misses the cache.
  - IDLE → WR_SETUP on a write edge.
  - RD → IDLE after WAIT_CYCLES cycles.
  - WR_SETUP → WR_PULSE after 1 cycle.
  - WR_PULSE → WR_HOLD after WAIT_CYCLES cycles.
  - WR_HOLD → IDLE after 1 cycle.
- **Lane selection.** `lb_n` = `addr[20]`, `ub_n` = ~`addr[20]`. Both lanes are high in IDLE.
- **Latching.** Address, lane and write data are latched at the request edge and held for the whole access.
- **Read data.** At the last RD cycle, `dout` is taken from `sram_dq_i[15:8]` when the latched `addr[20]` is 1, otherwise from `sram_dq_i[7:0]`. `dout` holds its value until the next completed read.
- **Read cache (one entry).** Holds a valid bit, a 21-bit address and 8-bit data.
  - A read edge whose address equals a valid cached address completes with no SRAM access: `dout` is loaded from the cache and `ready` never drops.
  - A completed SRAM read fills the cache.
  - A write to exactly the cached address updates the cached data with `din`.
  - A write to any other address leaves the cache unchanged.
- **Wait counter.** 4-bit down-counter. It is loaded with WAIT_CYCLES-1 on entry to RD or WR_PULSE, and the state exits when the count reaches 0.

## Timing
Let T be the cycle in which the edge is sampled.
- **Reset values (async):**
  - `ready`=1, `dout`=0, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0.
  - All strobes =1.
  - State IDLE, cache invalid.
  - Reset mid-access releases all strobes immediately; the access is lost.
- **Read miss:**
  - From T+1: `ready`=0, `oe_n`=0, lane strobe low.
  - At T+1+WAIT_CYCLES: `ready`=1, `oe_n`=1, `dout` valid.
  - `ready` is low for exactly WAIT_CYCLES cycles.
- **Read hit:** `ready` stays 1 and `dout` is valid at T+1.
- **Write:**
  - T+1: WR_SETUP.
  - T+2 .. T+1+WAIT_CYCLES: `we_n`=0.
  - T+2+WAIT_CYCLES: WR_HOLD.
  - T+3+WAIT_CYCLES: `ready`=1, `dq_oe`=0.
  - `ready` is low for WAIT_CYCLES+2 cycles.
- **Data setup and hold.** `sram_addr` and `sram_dq_o` are stable from the first to the last cycle of `dq_oe`. `we_n` is never low in the same cycle that the address changes.
- **Requests held past completion.** `rd` or `wr` still high after `ready` rises does not start a second access.

## Structure
- Package `gs_sram_pkg` holds:
  - the state enum (IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD);
  - the constants for the address and data widths.
- Single module, no sub-module. The edge detection and the cache are small enough to keep inline.

## Test plan
- **Read miss.** WAIT_CYCLES=2; SRAM model holds word 0x00010 = 0xA55A; rd edge with `addr`=0x100010.
  - Required: `ready` low at T+1 and T+2, high at T+3; `dout`=0xA5; `oe_n` low only in T+1..T+2; `ub_n`=0.
- **Read hit.** Repeat the read of 0x100010.
  - Required: no strobe activity, `ready` stays 1, `dout`=0xA5.
- **Write.** wr edge with `addr`=0x000010, `din`=0x3C.
  - Required: `we_n` low for 2 cycles; `lb_n`=0 and `ub_n`=1 throughout; `dq_oe` high one cycle before and one cycle after `we_n`; `ready` low for 4 cycles.
  - A following read of 0x000010 returns 0x3C.
- **Write updates cache, simultaneous request.** After a cached read of 0x100010, raise `rd` and `wr` together with `addr`=0x100010, `din`=0x77.
  - Required: only a write occurs; the next read is a hit returning 0x77.
- **Reset mid-write.** Assert `reset` during WR_PULSE.
  - Required: `we_n`=1, `dq_oe`=0, `ready`=1 in the same cycle; a subsequent read of the previously cached address goes to SRAM (cache invalid).
